// File: rtl/decode_queue_stage_if.sv
// Fetch-to-issue bus for the decode queue stage.
// Fetch push signals (in_*) and the decoded head entry (out_*) seen by issue.
interface decode_queue_stage_if #(
    parameter int OP_W = 6
);
    logic            in_valid;
    logic [31:0]     in_inst;
    logic [31:0]     in_pc;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_pc;
    logic [OP_W-1:0] out_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [31:0]     out_imm;
    logic            out_use_imm;
    logic            out_branch;
    logic            out_ls;
    logic            out_jalr;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_use_imm, out_branch, out_ls, out_jalr, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_use_imm, out_branch, out_ls, out_jalr, out_illegal
    );
endinterface

// File: rtl/decode_queue_stage.sv
// RV32I(+M) decode stage: instructions are decoded on push and held in a small
// FIFO of decoded entries; the oldest entry is presented to issue.
module decode_queue_stage #(
    parameter int DEPTH    = 4,
    parameter bit ENABLE_M = 1'b0,
    parameter int OP_W     = 6
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   flush_in,
    decode_queue_stage_if.slave    bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0),  OP_ADD  = OP_W'(1),  OP_SUB  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(3),  OP_SLT  = OP_W'(4),  OP_SLTU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XOR  = OP_W'(6),  OP_SRL  = OP_W'(7),  OP_SRA  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(9),  OP_AND  = OP_W'(10), OP_LB   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_LH   = OP_W'(12), OP_LW   = OP_W'(13), OP_LBU  = OP_W'(14);
    localparam logic [OP_W-1:0] OP_LHU  = OP_W'(15), OP_SB   = OP_W'(16), OP_SH   = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(18), OP_BEQ  = OP_W'(19), OP_BNE  = OP_W'(20);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(21), OP_BGE  = OP_W'(22), OP_BLTU = OP_W'(23);
    localparam logic [OP_W-1:0] OP_BGEU = OP_W'(24), OP_JAL  = OP_W'(25), OP_JALR = OP_W'(26);
    localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(27), OP_LUI = OP_W'(28), OP_MUL  = OP_W'(29);

    localparam logic [6:0] OPC_BIN = 7'b0110011, OPC_IMM = 7'b0010011, OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011, OPC_BR  = 7'b1100011, OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [31:0]     pc;
        logic [OP_W-1:0] op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            use_imm;
        logic            branch;
        logic            ls;
        logic            jalr;
        logic            illegal;
    } entry_t;

    function automatic logic [OP_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    alu_op = alt ? OP_SUB : OP_ADD;
            3'd1:    alu_op = OP_SLL;
            3'd2:    alu_op = OP_SLT;
            3'd3:    alu_op = OP_SLTU;
            3'd4:    alu_op = OP_XOR;
            3'd5:    alu_op = alt ? OP_SRA : OP_SRL;
            3'd6:    alu_op = OP_OR;
            default: alu_op = OP_AND;
        endcase
    endfunction

    logic [31:0] w_inst;
    logic [6:0]  w_opc;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_shamt;
    entry_t      w_dec;
    logic        w_bad;

    assign w_inst  = bus.in_inst;
    assign w_opc   = w_inst[6:0];
    assign w_f3    = w_inst[14:12];
    assign w_f7    = w_inst[31:25];
    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'd0};
    assign w_shamt = {27'd0, w_inst[24:20]};

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a latch.
        w_dec    = '0;
        w_bad    = 1'b0;
        w_dec.pc = bus.in_pc;
        case (w_opc)
            OPC_BIN: begin
                w_dec.rd  = w_inst[11:7];
                w_dec.rs1 = w_inst[19:15];
                w_dec.rs2 = w_inst[24:20];
                if (w_f7 == 7'b0000000)
                    w_dec.op = alu_op(w_f3, 1'b0);
                else if (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5))
                    w_dec.op = alu_op(w_f3, 1'b1);
                else if (ENABLE_M && w_f7 == 7'b0000001)
                    w_dec.op = OP_MUL + OP_W'(w_f3);
                else
                    w_bad = 1'b1;
            end
            OPC_IMM: begin
                w_dec.rd      = w_inst[11:7];
                w_dec.rs1     = w_inst[19:15];
                w_dec.use_imm = 1'b1;
                w_dec.op      = alu_op(w_f3, 1'b0);
                w_dec.imm     = w_imm_i;
                if (w_f3 == 3'd1) begin
                    w_dec.imm = w_shamt;
                    w_bad     = (w_f7 != 7'b0000000);
                end else if (w_f3 == 3'd5) begin
                    w_dec.imm = w_shamt;
                    w_dec.op  = alu_op(w_f3, w_f7[5]);
                    w_bad     = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                end
            end
            OPC_LD: begin
                w_dec.rd      = w_inst[11:7];
                w_dec.rs1     = w_inst[19:15];
                w_dec.imm     = w_imm_i;
                w_dec.use_imm = 1'b1;
                w_dec.ls      = 1'b1;
                case (w_f3)
                    3'd0:    w_dec.op = OP_LB;
                    3'd1:    w_dec.op = OP_LH;
                    3'd2:    w_dec.op = OP_LW;
                    3'd4:    w_dec.op = OP_LBU;
                    3'd5:    w_dec.op = OP_LHU;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_ST: begin
                w_dec.rs1     = w_inst[19:15];
                w_dec.rs2     = w_inst[24:20];
                w_dec.imm     = w_imm_s;
                w_dec.use_imm = 1'b1;
                w_dec.ls      = 1'b1;
                case (w_f3)
                    3'd0:    w_dec.op = OP_SB;
                    3'd1:    w_dec.op = OP_SH;
                    3'd2:    w_dec.op = OP_SW;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_BR: begin
                w_dec.rs1    = w_inst[19:15];
                w_dec.rs2    = w_inst[24:20];
                w_dec.imm    = w_imm_b;
                w_dec.branch = 1'b1;
                case (w_f3)
                    3'd0:    w_dec.op = OP_BEQ;
                    3'd1:    w_dec.op = OP_BNE;
                    3'd4:    w_dec.op = OP_BLT;
                    3'd5:    w_dec.op = OP_BGE;
                    3'd6:    w_dec.op = OP_BLTU;
                    3'd7:    w_dec.op = OP_BGEU;
                    default: w_bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                w_dec.rd      = w_inst[11:7];
                w_dec.imm     = w_imm_j;
                w_dec.use_imm = 1'b1;
                w_dec.branch  = 1'b1;
                w_dec.op      = OP_JAL;
            end
            OPC_JALR: begin
                w_dec.rd      = w_inst[11:7];
                w_dec.rs1     = w_inst[19:15];
                w_dec.imm     = w_imm_i;
                w_dec.use_imm = 1'b1;
                w_dec.jalr    = 1'b1;
                w_dec.op      = OP_JALR;
                w_bad         = (w_f3 != 3'd0);
            end
            OPC_LUI, OPC_AUIPC: begin
                w_dec.rd      = w_inst[11:7];
                w_dec.imm     = w_imm_u;
                w_dec.use_imm = 1'b1;
                w_dec.op      = (w_opc == OPC_LUI) ? OP_LUI : OP_AUIPC;
            end
            default: w_bad = 1'b1;
        endcase
        // Illegal entries keep only their pc so issue can still report the fault address.
        if (w_bad) begin
            w_dec         = '0;
            w_dec.pc      = bus.in_pc;
            w_dec.op      = OP_NOP;
            w_dec.illegal = 1'b1;
        end
    end

    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_valid;
    entry_t           r_mem [DEPTH];
    entry_t           w_head;
    logic             w_in_ready, w_out_valid, w_push, w_pop;

    assign w_in_ready  = (r_count < CNT_W'(DEPTH)) & ~rst_in;
    assign w_out_valid = r_valid[r_head] & ~rst_in;
    assign w_push      = bus.in_valid & w_in_ready & ~flush_in;
    assign w_pop       = w_out_valid & bus.out_ready & ~flush_in;

    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses <= so all registers update from pre-edge values.
        if (rst_in || flush_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_push && !w_pop)
                r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // NOTE: payload storage has no reset; the valid bits alone qualify its contents.
    always_ff @(posedge clk_in) begin
        if (w_push)
            r_mem[r_tail] <= w_dec;
    end

    assign w_head          = rst_in ? '0 : r_mem[r_head];
    assign count           = r_count;
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_pc      = w_head.pc;
    assign bus.out_op      = w_head.op;
    assign bus.out_rd      = w_head.rd;
    assign bus.out_rs1     = w_head.rs1;
    assign bus.out_rs2     = w_head.rs2;
    assign bus.out_imm     = w_head.imm;
    assign bus.out_use_imm = w_head.use_imm;
    assign bus.out_branch  = w_head.branch;
    assign bus.out_ls      = w_head.ls;
    assign bus.out_jalr    = w_head.jalr;
    assign bus.out_illegal = w_head.illegal;
endmodule
